// File: rtl/instr_fetch_sequencer.sv
// instr_fetch_sequencer: 16-word program store plus program counter.
// Presents one qualified instruction per cycle to decode/datapath, with
// run / single-step / halt-on-sentinel / restart control.
module instr_fetch_sequencer #(
    parameter int                  ADDR_W    = 4,
    parameter int                  INSTR_W   = 12,
    parameter logic [INSTR_W-1:0]  HALT_WORD = 12'hFFF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_en,
    input  logic [ADDR_W-1:0]  load_addr,
    input  logic [INSTR_W-1:0] load_data,
    input  logic               run,
    input  logic               step,
    input  logic               restart,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    output logic [ADDR_W-1:0]  pc,
    output logic               busy,
    output logic               halted
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               instr_valid_q, instr_valid_d;
    logic               step_q;
    logic [INSTR_W-1:0] mem_q [DEPTH];

    logic               step_edge;
    logic               load_ok;
    logic               fetch;
    logic [INSTR_W-1:0] mem_rd;

    // Loads are blocked while sequencing so the program cannot change under the pc.
    assign load_ok   = load_en && (state_q != S_RUN);
    assign step_edge = step && !step_q;
    assign mem_rd    = mem_q[pc_q];

    // Next-state, fetch and pc logic; restart overrides everything else.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_valid_d = 1'b0;
        fetch         = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A load in the same cycle swallows the step edge.
                fetch = step_edge && !load_en;
                if (run && !load_en) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (run) begin
                    fetch = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (fetch) begin
            if (mem_rd == HALT_WORD) begin
                state_d = S_HALT;
            end else begin
                instr_d       = mem_rd;
                instr_valid_d = 1'b1;
                pc_d          = pc_q + ADDR_W'(1);
            end
        end

        if (restart) begin
            state_d       = S_IDLE;
            pc_d          = '0;
            instr_d       = instr_q;
            instr_valid_d = 1'b0;
        end
    end

    // Sequencer registers; reset drops the execute strobe immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            pc_q          <= '0;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            step_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            step_q        <= step;
        end
    end

    // Program store; reset fills it with the sentinel so an empty program halts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= HALT_WORD;
            end
        end else if (load_ok) begin
            mem_q[load_addr] <= load_data;
        end
    end

    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign pc          = pc_q;
    assign busy        = (state_q == S_RUN);
    assign halted      = (state_q == S_HALT);

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Directed self-checking bench for instr_fetch_sequencer.
module tb_instr_fetch_sequencer;

    logic        clk;
    logic        reset;
    logic        load_en;
    logic [3:0]  load_addr;
    logic [11:0] load_data;
    logic        run;
    logic        step;
    logic        restart;
    logic [11:0] instr;
    logic        instr_valid;
    logic [3:0]  pc;
    logic        busy;
    logic        halted;

    int n_checks = 0;
    int n_pass   = 0;

    instr_fetch_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .run        (run),
        .step       (step),
        .restart    (restart),
        .instr      (instr),
        .instr_valid(instr_valid),
        .pc         (pc),
        .busy       (busy),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [3:0] a, input logic [11:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        tick();
        load_en   = 1'b0;
    endtask

    logic [11:0] prog [3];

    initial begin
        prog[0] = 12'h123;
        prog[1] = 12'h456;
        prog[2] = 12'h789;
        reset = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
        run = 1'b0; step = 1'b0; restart = 1'b0;
        #12;
        chk("rst_valid", instr_valid, 0);
        chk("rst_pc", pc, 0);
        chk("rst_instr", instr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);
        @(negedge clk);
        reset = 1'b1;

        // Empty program halts two edges after run.
        run = 1'b1;
        tick();
        chk("empty_busy", busy, 1);
        chk("empty_valid1", instr_valid, 0);
        tick();
        chk("empty_halted", halted, 1);
        chk("empty_busy2", busy, 0);
        chk("empty_valid2", instr_valid, 0);
        chk("empty_pc", pc, 0);
        run = 1'b0;

        // Load three words while halted, restart, then run.
        for (int i = 0; i < 3; i++) load_word(4'(i), prog[i]);
        chk("halt_pc_after_load", pc, 0);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk("rs_halted", halted, 0);
        run = 1'b1;
        tick();
        chk("run_busy", busy, 1);
        chk("run_first_latency", instr_valid, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("run_valid%0d", i), instr_valid, 1);
            chk($sformatf("run_instr%0d", i), instr, 32'(prog[i]));
            chk($sformatf("run_pc%0d", i), pc, i + 1);
        end
        tick();
        chk("run_halted", halted, 1);
        chk("run_halt_valid", instr_valid, 0);
        chk("run_halt_pc", pc, 3);
        chk("run_halt_instr", instr, 12'h789);
        run = 1'b0;

        // Single step: a held step yields exactly one pulse.
        restart = 1'b1;
        tick();
        restart = 1'b0;
        step = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("step_valid%0d", i), instr_valid, (i == 0) ? 1 : 0);
            chk($sformatf("step_pc%0d", i), pc, 1);
        end
        chk("step_instr", instr, 12'h123);
        step = 1'b0;
        tick();
        step = 1'b1;
        tick();
        chk("step2_valid", instr_valid, 1);
        chk("step2_instr", instr, 12'h456);
        chk("step2_pc", pc, 2);
        step = 1'b0;
        tick();
        chk("step2_drop", instr_valid, 0);

        // Fill with 0x001 and run continuously across the pc wrap.
        for (int i = 0; i < 16; i++) load_word(4'(i), 12'h001);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        run = 1'b1;
        tick();
        for (int k = 0; k < 20; k++) begin
            tick();
            chk($sformatf("wrap_valid%0d", k), instr_valid, 1);
            chk($sformatf("wrap_instr%0d", k), instr, 1);
            chk($sformatf("wrap_pc%0d", k), pc, (k + 1) % 16);
        end

        // Load in RUN is ignored: every later fetch still returns 0x001.
        load_word(4'd5, 12'h0AA);
        for (int k = 0; k < 17; k++) begin
            tick();
            chk($sformatf("runload_instr%0d", k), instr, 1);
        end
        run = 1'b0;
        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk("restart_pc", pc, 0);
        chk("restart_busy", busy, 0);
        chk("restart_halted", halted, 0);
        chk("restart_valid", instr_valid, 0);

        // Asynchronous reset mid-RUN.
        run = 1'b1;
        tick();
        tick();
        tick();
        chk("pre_reset_valid", instr_valid, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_valid", instr_valid, 0);
        chk("async_pc", pc, 0);
        chk("async_busy", busy, 0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        chk("post_rst_busy", busy, 1);
        tick();
        chk("post_rst_halted", halted, 1);
        chk("post_rst_valid", instr_valid, 0);
        chk("post_rst_pc", pc, 0);
        run = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
